collision_matrix_ctrl: RTL and testbench
========================================

COLLISION_MATRIX_CTRL -- requirements
Module: collision_matrix_ctrl

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 4, meaning number of drawing-request layers (legal 2..8).
REQ-002 SHALL have parameter PAIR_MASK, default all ones, meaning NUM_PAIRS-bit enable per object pair; NUM_PAIRS = NUM_OBJ*(NUM_OBJ-1)/2.
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of each per-pair frame counter.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port resetN, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port startOfFrame, input, 1, one-cycle frame-boundary strobe.
REQ-007 SHALL have port drawingRequest, input, NUM_OBJ, per-layer pixel request for the current pixel.
REQ-008 SHALL have port hold_req, input, 1, freeze collision accumulation.
REQ-009 SHALL have port report_ack, input, 1, consumer accepts report_data.
REQ-010 SHALL have port clear_counts, input, 1, zero all pair counters.
REQ-011 SHALL have port live_hit, output, NUM_PAIRS, registered per-pair pixel overlap.
REQ-012 SHALL have port first_hit_pulse, output, NUM_PAIRS, one-cycle pulse on a pair's first overlap in a frame.
REQ-013 SHALL have port SingleHitPulse, output, 1, at most one pulse per frame on first overlap of any pair.
REQ-014 SHALL have port report_data, output, NUM_PAIRS, per-pair collided flags of the last completed frame.
REQ-015 SHALL have port report_valid, output, 1, report_data pending.
REQ-016 SHALL have port report_overrun, output, 1, sticky: report overwritten before ack.
REQ-017 SHALL have port pair_count, output, NUM_PAIRS*CNT_W, per-pair count of frames containing a collision.

Function
REQ-018 Pair index k SHALL enumerate (i,j), i<j, ascending i then j; NUM_OBJ=4 gives (0,1)=0,(0,2)=1,(0,3)=2,(1,2)=3,(1,3)=4,(2,3)=5.
REQ-019 hit_now[k] SHALL be drawingRequest[i] & drawingRequest[j] & PAIR_MASK[k], qualified by state RUN.
REQ-020 FSM SHALL have states WAIT_SOF, RUN, HOLD; reset enters WAIT_SOF; WAIT_SOF->RUN on startOfFrame; RUN->HOLD when hold_req=1; HOLD->RUN on startOfFrame with hold_req=0.
REQ-021 In WAIT_SOF and HOLD, hit_now SHALL be forced 0; accumulators retained, not updated.
REQ-022 live_hit SHALL equal hit_now delayed by exactly 1 cycle.
REQ-023 frame accumulator acc[k] SHALL be sticky OR of hit_now[k] within a frame; on startOfFrame acc SHALL load hit_now of that same cycle (boundary cycle belongs to new frame).
REQ-024 first_hit_pulse[k] SHALL be 1 for one cycle, 1 cycle after the first cycle with hit_now[k]=1 and acc[k]=0 (or startOfFrame).
REQ-025 SingleHitPulse SHALL pulse once, 1 cycle after the first cycle any first_hit condition holds; a per-frame flag blocks further pulses until next startOfFrame.
REQ-026 On startOfFrame (state RUN or HOLD), report_data SHALL load acc (pre-boundary value) and report_valid SHALL set.
REQ-027 report_ack with report_valid=1 and no startOfFrame SHALL clear report_valid next cycle; ack with report_valid=0 SHALL be ignored.
REQ-028 startOfFrame with report_valid=1 and report_ack=0 SHALL overwrite report_data and set report_overrun; with report_ack=1 same cycle, new report loads, valid stays 1, no overrun.
REQ-029 report_overrun SHALL clear only on reset.

Reset
REQ-030 Reset SHALL zero live_hit, first_hit_pulse, SingleHitPulse, report_data, report_valid, report_overrun, pair_count, acc, frame flag; state WAIT_SOF.
REQ-031 Reset asserted mid-frame SHALL discard accumulated hits; no report or pulse generated for that frame.

Configuration
REQ-032 Macro COLLISION_COUNT_EN defined: each pair_count field SHALL increment by 1 on startOfFrame when acc[k]=1, saturate at 2^CNT_W-1; clear_counts SHALL zero all fields next cycle, priority over increment.
REQ-033 Macro COLLISION_COUNT_EN undefined: pair_count SHALL be constant 0, clear_counts ignored, ports retained.

Structure
REQ-034 Package collision_pkg SHALL hold FSM state enum, MAX_OBJ=8, pair-count and pair-index functions.
REQ-035 Per-pair logic (acc, first-hit pulse, counter) SHALL be sub-module collision_pair_cell, generated NUM_PAIRS times.

Verification (NUM_OBJ=4, defaults)
REQ-036 Reset, SOF, drawingRequest=4'b0011 for 3 cycles -> live_hit=6'b000001 cycles 1-3 after, first_hit_pulse[0] and SingleHitPulse once each.
REQ-037 Same frame: 4'b0011 then 4'b1010 -> first_hit_pulse[0] then [4]; SingleHitPulse only once; next SOF -> report_data=6'b010001, report_valid=1.
REQ-038 Two SOFs without ack -> report_overrun=1; SOF with simultaneous ack -> report_valid stays 1, report_overrun unchanged.
REQ-039 hold_req=1, drawingRequest=4'b1111 -> live_hit=0, no pulses; release, SOF -> hits resume.
REQ-040 COLLISION_COUNT_EN, CNT_W=2, pair 0 hit in 5 frames -> pair_count[0]=3 (saturated); clear_counts -> 0.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and helpers for the collision matrix controller: FSM state
// encoding, the object-count ceiling, and the (i,j) -> pair index mapping.
package collision_pkg;

    localparam int MAX_OBJ = 8;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        RUN      = 2'd1,
        HOLD     = 2'd2
    } state_t;

    // Number of unordered object pairs for n objects.
    function automatic int num_pairs(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    // Pairs are numbered (0,1),(0,2),...,(0,n-1),(1,2),... with i<j.
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/collision_pair_cell.sv
// One object pair: registered live hit, per-frame sticky accumulator,
// first-hit pulse and (when COLLISION_COUNT_EN is defined) a saturating
// count of frames that contained a collision.
module collision_pair_cell #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit,
    input  logic             sof,
    input  logic             frame_end,
    input  logic             clear,
    output logic             live_hit,
    output logic             first_cond,
    output logic             first_hit_pulse,
    output logic             acc,
    output logic [CNT_W-1:0] count
);

    // The boundary cycle starts a new frame, so a hit on it is a first hit.
    assign first_cond = hit & (sof | ~acc);

    // Live hit delay, first-hit pulse and frame accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_hit        <= 1'b0;
            first_hit_pulse <= 1'b0;
            acc             <= 1'b0;
        end else begin
            live_hit        <= hit;
            first_hit_pulse <= first_cond;
            acc             <= sof ? hit : (acc | hit);
        end
    end

`ifdef COLLISION_COUNT_EN
    // Frame counter: clear wins over increment, saturates at all ones.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (frame_end && acc && !(&count)) begin
            count <= count + 1'b1;
        end
    end
`else
    logic unused_cnt_in;
    assign unused_cnt_in = clear ^ frame_end;
    assign count         = '0;
`endif

endmodule

// File: rtl/collision_matrix_ctrl.sv
// Pairwise collision detector over NUM_OBJ drawing-request layers.
// Optional per-pair frame counters are built when COLLISION_COUNT_EN is
// defined; otherwise pair_count reads constant zero.
module collision_matrix_ctrl
    import collision_pkg::*;
#(
    parameter int  NUM_OBJ   = 4,
    parameter int  CNT_W     = 8,
    localparam int NUM_PAIRS = num_pairs(NUM_OBJ),
    parameter logic [NUM_PAIRS-1:0] PAIR_MASK = '1
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [NUM_OBJ-1:0]         drawingRequest,
    input  logic                       hold_req,
    input  logic                       report_ack,
    input  logic                       clear_counts,
    output logic [NUM_PAIRS-1:0]       live_hit,
    output logic [NUM_PAIRS-1:0]       first_hit_pulse,
    output logic                       SingleHitPulse,
    output logic [NUM_PAIRS-1:0]       report_data,
    output logic                       report_valid,
    output logic                       report_overrun,
    output logic [NUM_PAIRS*CNT_W-1:0] pair_count
);

    state_t               state;
    logic [NUM_PAIRS-1:0] pair_req;
    logic [NUM_PAIRS-1:0] hit_now;
    logic [NUM_PAIRS-1:0] first_cond;
    logic [NUM_PAIRS-1:0] acc;
    logic                 frame_flag;
    logic                 frame_end;
    logic                 any_first;

    // Raw pairwise overlap of the current pixel.
    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_i
        for (genvar j = i + 1; j < NUM_OBJ; j++) begin : g_j
            localparam int K = pair_idx(i, j, NUM_OBJ);
            assign pair_req[K] = drawingRequest[i] & drawingRequest[j];
        end
    end

    assign hit_now   = (state == RUN) ? (pair_req & PAIR_MASK) : '0;
    // A boundary only closes a frame once a frame has actually been opened.
    assign frame_end = startOfFrame & (state != WAIT_SOF);
    assign any_first = |first_cond;

    // Frame-tracking FSM.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state <= WAIT_SOF;
        end else begin
            case (state)
                WAIT_SOF: if (startOfFrame)              state <= RUN;
                RUN:      if (hold_req)                  state <= HOLD;
                HOLD:     if (startOfFrame && !hold_req) state <= RUN;
                default:                                 state <= WAIT_SOF;
            endcase
        end
    end

    // One global pulse per frame on the first overlap of any pair.
    always_ff @(posedge clk) begin
        if (resetN) begin
            SingleHitPulse <= 1'b0;
            frame_flag     <= 1'b0;
        end else begin
            SingleHitPulse <= any_first & (startOfFrame | ~frame_flag);
            frame_flag     <= startOfFrame ? any_first : (frame_flag | any_first);
        end
    end

    // Report handshake: capture previous frame at each boundary.
    always_ff @(posedge clk) begin
        if (resetN) begin
            report_data    <= '0;
            report_valid   <= 1'b0;
            report_overrun <= 1'b0;
        end else if (frame_end) begin
            report_data  <= acc;
            report_valid <= 1'b1;
            if (report_valid && !report_ack) report_overrun <= 1'b1;
        end else if (report_ack && report_valid) begin
            report_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair
        collision_pair_cell #(
            .CNT_W(CNT_W)
        ) u_cell (
            .clk            (clk),
            .rst            (resetN),
            .hit            (hit_now[k]),
            .sof            (startOfFrame),
            .frame_end      (frame_end),
            .clear          (clear_counts),
            .live_hit       (live_hit[k]),
            .first_cond     (first_cond[k]),
            .first_hit_pulse(first_hit_pulse[k]),
            .acc            (acc[k]),
            .count          (pair_count[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_collision_matrix_ctrl.sv
// Bench for collision_matrix_ctrl (NUM_OBJ=4, CNT_W=2). Directed scenarios
// followed by random traffic, all compared against a frame-level model.
module tb_collision_matrix_ctrl;

    localparam int NO  = 4;
    localparam int NP  = 6;
    localparam int CW  = 2;
    localparam logic [NP-1:0] MASK = '1;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              resetN = 1'b1;
    logic              sof = 1'b0;
    logic [NO-1:0]     dr = '0;
    logic              hold_req = 1'b0;
    logic              report_ack = 1'b0;
    logic              clear_counts = 1'b0;
    logic [NP-1:0]     live_hit;
    logic [NP-1:0]     first_hit_pulse;
    logic              SingleHitPulse;
    logic [NP-1:0]     report_data;
    logic              report_valid;
    logic              report_overrun;
    logic [NP*CW-1:0]  pair_count;

    always #5 clk = ~clk;

    collision_matrix_ctrl #(.NUM_OBJ(NO), .CNT_W(CW)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (sof),
        .drawingRequest (dr),
        .hold_req       (hold_req),
        .report_ack     (report_ack),
        .clear_counts   (clear_counts),
        .live_hit       (live_hit),
        .first_hit_pulse(first_hit_pulse),
        .SingleHitPulse (SingleHitPulse),
        .report_data    (report_data),
        .report_valid   (report_valid),
        .report_overrun (report_overrun),
        .pair_count     (pair_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pair table plus per-frame bookkeeping.
    int         pi [NP];
    int         pj [NP];
    int         mode;          // 0 waiting for first frame, 1 running, 2 held
    bit         seen [NP];     // pair already collided in current frame
    bit         any_seen;      // some pair already collided in current frame
    logic [NP-1:0] e_live, e_fhp, e_rep;
    bit         e_shp, e_rv, e_ov;
    int         cnt [NP];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode = 0; any_seen = 0;
        e_live = '0; e_fhp = '0; e_rep = '0;
        e_shp = 0; e_rv = 0; e_ov = 0;
        for (int k = 0; k < NP; k++) begin
            seen[k] = 0; cnt[k] = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [NP*CW-1:0] ec;
        ec = '0;
        for (int k = 0; k < NP; k++) ec[k*CW +: CW] = cnt[k][CW-1:0];
        chk({tag, ".live"},  live_hit,        e_live);
        chk({tag, ".fhp"},   first_hit_pulse, e_fhp);
        chk({tag, ".shp"},   SingleHitPulse,  e_shp);
        chk({tag, ".rdata"}, report_data,     e_rep);
        chk({tag, ".rv"},    report_valid,    e_rv);
        chk({tag, ".ovr"},   report_overrun,  e_ov);
        chk({tag, ".cnt"},   pair_count,      ec);
    endtask

    // One clock with the given inputs; model advanced and outputs compared.
    task automatic cyc(input bit s, input logic [NO-1:0] d, input bit h,
                       input bit a, input bit c, input string tag);
        bit hit [NP];
        bit newhit;
        bit closing;
        sof = s; dr = d; hold_req = h; report_ack = a; clear_counts = c;
        newhit = 0;
        closing = s && (mode != 0);
        for (int k = 0; k < NP; k++) begin
            hit[k] = (mode == 1) && d[pi[k]] && d[pj[k]] && MASK[k];
            e_live[k] = hit[k];
            e_fhp[k]  = hit[k] && (s || !seen[k]);
            if (e_fhp[k]) newhit = 1;
        end
        e_shp = newhit && (s || !any_seen);
        if (closing) begin
            for (int k = 0; k < NP; k++) e_rep[k] = seen[k];
            if (e_rv && !a) e_ov = 1;
            e_rv = 1;
        end else if (a && e_rv) begin
            e_rv = 0;
        end
        for (int k = 0; k < NP; k++) begin
`ifdef COLLISION_COUNT_EN
            if (c) cnt[k] = 0;
            else if (closing && seen[k] && cnt[k] < CMAX) cnt[k]++;
`else
            cnt[k] = 0;
`endif
            seen[k] = s ? hit[k] : (seen[k] || hit[k]);
        end
        any_seen = s ? newhit : (any_seen || newhit);
        case (mode)
            0: if (s) mode = 1;
            1: if (h) mode = 2;
            default: if (s && !h) mode = 1;
        endcase
        @(posedge clk); #1;
        compare_all(tag);
    endtask

    task automatic rst_cyc();
        resetN = 1'b1;
        sof = 0; dr = '0; hold_req = 0; report_ack = 0; clear_counts = 0;
        @(posedge clk); #1;
        resetN = 1'b0;
        model_reset();
        compare_all("reset");
    endtask

    initial begin
        int k;
        k = 0;
        for (int i = 0; i < NO; i++)
            for (int j = i + 1; j < NO; j++) begin
                pi[k] = i; pj[k] = j; k++;
            end
        model_reset();
        @(posedge clk); #1;
        rst_cyc();
        chk("reset_state_literal", {live_hit, report_valid, report_overrun, pair_count}, '0);

        // Single pair overlap for three pixels.
        cyc(1, 4'b0000, 0, 0, 0, "sof1");
        cyc(0, 4'b0011, 0, 0, 0, "p01_a");
        chk("p01_a_live_lit", live_hit, 6'b000001);
        chk("p01_a_fhp_lit", first_hit_pulse, 6'b000001);
        chk("p01_a_shp_lit", SingleHitPulse, 1'b1);
        cyc(0, 4'b0011, 0, 0, 0, "p01_b");
        chk("p01_b_fhp_lit", first_hit_pulse, 6'b000000);
        chk("p01_b_shp_lit", SingleHitPulse, 1'b0);
        cyc(0, 4'b0011, 0, 0, 0, "p01_c");
        chk("p01_c_live_lit", live_hit, 6'b000001);
        // Second pair in same frame: its own pulse, no global pulse.
        cyc(0, 4'b1010, 0, 0, 0, "p13");
        chk("p13_fhp_lit", first_hit_pulse, 6'b010000);
        chk("p13_shp_lit", SingleHitPulse, 1'b0);
        cyc(0, 4'b0000, 0, 0, 0, "idle");
        cyc(1, 4'b0000, 0, 0, 0, "sof2");
        chk("report_lit", report_data, 6'b010001);
        chk("report_valid_lit", report_valid, 1'b1);

        // Overrun, then boundary with simultaneous ack, then plain ack.
        cyc(1, 4'b0000, 0, 0, 0, "sof3_noack");
        chk("overrun_lit", report_overrun, 1'b1);
        cyc(1, 4'b0000, 0, 1, 0, "sof4_ack");
        chk("sof_ack_valid_lit", report_valid, 1'b1);
        cyc(0, 4'b0000, 0, 1, 0, "ack");
        chk("ack_clear_lit", report_valid, 1'b0);
        cyc(0, 4'b0000, 0, 1, 0, "ack_idle");

        // Hold freezes accumulation.
        cyc(0, 4'b0000, 1, 0, 0, "hold_enter");
        for (int n = 0; n < 3; n++) begin
            cyc(0, 4'b1111, 1, 0, 0, "hold_all");
            chk("hold_live_lit", live_hit, 6'b000000);
        end
        cyc(1, 4'b1111, 0, 0, 0, "hold_release");
        cyc(0, 4'b1111, 0, 1, 0, "resume");
        chk("resume_live_lit", live_hit, 6'b111111);

        // Five collided frames on pair 0 saturate a 2-bit counter.
        for (int n = 0; n < 5; n++) cyc(1, 4'b0011, 0, 1, 0, "cnt_frame");
        cyc(1, 4'b0000, 0, 1, 0, "cnt_close");
`ifdef COLLISION_COUNT_EN
        chk("cnt_sat_lit", pair_count[CW-1:0], 2'd3);
`else
        chk("cnt_off_lit", pair_count, '0);
`endif
        cyc(0, 4'b0000, 0, 0, 1, "cnt_clear");
        chk("cnt_clear_lit", pair_count[CW-1:0], 2'd0);

        // Reset mid-frame drops the frame in progress.
        cyc(1, 4'b0000, 0, 1, 0, "mf_sof");
        cyc(0, 4'b0110, 0, 0, 0, "mf_hit");
        rst_cyc();
        cyc(1, 4'b0000, 0, 0, 0, "mf_after_sof");
        chk("mf_no_report_lit", report_valid, 1'b0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) == 0) rst_cyc();
            else cyc($urandom_range(7) == 0, 4'($urandom), $urandom_range(9) == 0,
                     $urandom_range(3) == 0, $urandom_range(29) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
